systolic_seq: RTL and testbench

SYSTOLIC_SEQ -- requirements
Module: systolic_seq

---
 rtl/systolic_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_systolic_seq.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
//
// Sequencer for an external N x N output-stationary systolic array. It accepts
// one job at a time. It streams k_len operand beats into the array with a
// per-row and per-column skew, then waits for the array to drain. It snapshots
// every PE accumulator and returns the result matrix one row per handshake.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   start, k_len           job request (sampled in IDLE only), beat count
//   busy                   high whenever the sequencer is not IDLE
//   op_valid/op_ready      operand beat handshake
//   op_a, op_b             A column k (slice i -> row i), B row k (slice j -> col j)
//   arr_init               accumulator-clear pulse, aligned with the first beat
//   arr_x, arr_y           skewed row / column feeds into the array
//   arr_z                  PE accumulator outputs
//   res_valid/res_ready    result row handshake
//   res_row, res_idx       result row r (slice j = C[r][j]) and its index
//   res_last               marks row N-1
//   done                   one-cycle pulse after the last row transfer
//
// Optional feature (macro SYSTOLIC_SEQ_PERF_EN):
//   perf_cycles            saturating count of cycles from start acceptance
//                          through the done cycle, held until the next job
// -----------------------------------------------------------------------------
module systolic_seq #(
    parameter  int D_W   = 8,
    parameter  int N     = 2,
    parameter  int K_W   = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [K_W-1:0]                 k_len,
    output logic                           busy,
    input  logic                           op_valid,
    output logic                           op_ready,
    input  logic [N*D_W-1:0]               op_a,
    input  logic [N*D_W-1:0]               op_b,
    output logic                           arr_init,
    output logic [N-1:0][D_W-1:0]          arr_x,
    output logic [N-1:0][D_W-1:0]          arr_y,
    input  logic [N-1:0][N-1:0][2*D_W-1:0] arr_z,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [N*2*D_W-1:0]             res_row,
    output logic [IDX_W-1:0]               res_idx,
    output logic                           res_last,
    output logic                           done
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]                    perf_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    // The drain has to cover the longest skew path: the last beat of row N-1 needs
    // N-1 cycles to enter the array and N-1 more to reach column N-1.
    localparam int               DR_W       = $clog2(2 * N);
    localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(2 * N - 1);
    localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(N - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_start_ok;
    logic                           w_beat;
    logic                           w_last_beat;
    logic                           w_drain_end;
    logic                           w_res_xfer;
    logic [K_W-1:0]                 r_k_len;
    logic [K_W-1:0]                 r_beat;
    logic [DR_W-1:0]                r_drain;
    logic [IDX_W-1:0]               r_row;
    logic                           r_init;
    logic                           r_done;
    logic [N-1:0][N-1:0][2*D_W-1:0] r_snap;

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path leaves it unassigned (which would infer a latch).
        w_state_nxt = r_state;
        busy        = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        w_start_ok  = 1'b0;
        w_beat      = 1'b0;
        w_last_beat = 1'b0;
        w_drain_end = 1'b0;
        w_res_xfer  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A zero-length job has nothing to multiply and is dropped.
                if (start && (k_len != '0)) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = FEED;
                end
            end
            FEED: begin
                busy        = 1'b1;
                op_ready    = 1'b1;
                w_beat      = op_valid;
                w_last_beat = op_valid && (r_beat == (r_k_len - K_W'(1)));
                if (w_last_beat) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy        = 1'b1;
                w_drain_end = (r_drain == DRAIN_LAST);
                if (w_drain_end) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                busy       = 1'b1;
                res_valid  = 1'b1;
                w_res_xfer = res_ready;
                if (res_ready && (r_row == LAST_ROW)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_k_len <= '0;
            r_beat  <= '0;
            r_drain <= '0;
            r_row   <= '0;
            r_init  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            // The clear pulse rides alongside the first beat as it leaves stage 0.
            r_init  <= w_beat && (r_beat == '0);
            r_done  <= w_res_xfer && (r_row == LAST_ROW);

            if (w_start_ok) begin
                r_k_len <= k_len;
                r_beat  <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + K_W'(1);
            end

            if ((r_state != DRAIN) || w_drain_end) begin
                r_drain <= '0;
            end else begin
                r_drain <= r_drain + DR_W'(1);
            end

            if (w_res_xfer) begin
                r_row <= (r_row == LAST_ROW) ? '0 : (r_row + IDX_W'(1));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result snapshot: frozen at the end of DRAIN so the array may be reused
    // while rows are being read out.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this storage is cleared on reset so no result from an aborted job can leak out afterwards.
            r_snap <= '0;
        end else if (w_drain_end) begin
            r_snap <= arr_z;
        end
    end

    // -------------------------------------------------------------------------
    // Skew lanes: lane i delays both its row feed and its column feed by i extra
    // cycles. Stage 0 loads zero on any cycle without an accepted beat, so stalls
    // and idle slots contribute zero products and keep the wavefront aligned.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [D_W-1:0] r_xd [0:gi];
        logic [D_W-1:0] r_yd [0:gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= gi; s++) begin
                    r_xd[s] <= '0;
                    r_yd[s] <= '0;
                end
            end else begin
                r_xd[0] <= w_beat ? op_a[gi*D_W +: D_W] : '0;
                r_yd[0] <= w_beat ? op_b[gi*D_W +: D_W] : '0;
                for (int s = 1; s <= gi; s++) begin
                    r_xd[s] <= r_xd[s-1];
                    r_yd[s] <= r_yd[s-1];
                end
            end
        end

        assign arr_x[gi] = r_xd[gi];
        assign arr_y[gi] = r_yd[gi];
    end

    assign arr_init = r_init;
    assign done     = r_done;
    assign res_row  = (r_state == OUT) ? r_snap[r_row] : '0;
    assign res_idx  = (r_state == OUT) ? r_row : '0;
    assign res_last = (r_state == OUT) && (r_row == LAST_ROW);

`ifdef SYSTOLIC_SEQ_PERF_EN
    // -------------------------------------------------------------------------
    // Job latency counter. The acceptance cycle counts as 1. Every busy cycle and
    // the done cycle add one. The value then holds until the next job starts.
    // -------------------------------------------------------------------------
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (w_start_ok) begin
            r_perf <= 32'd1;
        end else if ((busy || r_done) && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
//
// Testbench for systolic_seq with N=2 and D_W=8. The bench contains a
// behavioural model of the N x N PE array. Each PE passes x to the right and y
// downward, and adds x*y into its accumulator. arr_init restarts every
// accumulator.
//
// Expected result rows come from a plain matrix product of the operands issued
// for each job. They are queued when the job is issued. A negedge monitor pops
// and compares them on every result transfer. The same monitor also tracks
// these properties:
//   - arr_x/arr_y: each lane must show the beat accepted i edges earlier,
//     or zero.
//   - arr_init: high only alongside the first beat of a job.
//   - done: must pulse in the cycle after the last row.
// -----------------------------------------------------------------------------
module tb_systolic_seq;

    localparam int D_W   = 8;
    localparam int N     = 2;
    localparam int K_W   = 8;
    localparam int IDX_W = 1;
    localparam int AW    = N * D_W;
    localparam int ZW    = 2 * D_W;
    localparam int RW    = N * ZW;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [K_W-1:0]              k_len;
    logic                        busy;
    logic                        op_valid;
    logic                        op_ready;
    logic [AW-1:0]               op_a;
    logic [AW-1:0]               op_b;
    logic                        arr_init;
    logic [N-1:0][D_W-1:0]       arr_x;
    logic [N-1:0][D_W-1:0]       arr_y;
    logic                        res_valid;
    logic                        res_ready;
    logic [RW-1:0]               res_row;
    logic [IDX_W-1:0]            res_idx;
    logic                        res_last;
    logic                        done;

    // PE array model state
    logic [N-1:0][N-1:0][D_W-1:0] pe_x, pe_y, pe_xin, pe_yin;
    logic [N-1:0][N-1:0][ZW-1:0]  pe_acc;

    systolic_seq #(.D_W(D_W), .N(N), .K_W(K_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .arr_init  (arr_init),
        .arr_x     (arr_x),
        .arr_y     (arr_y),
        .arr_z     (pe_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .res_idx   (res_idx),
        .res_last  (res_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // PE array model
    // -------------------------------------------------------------------------
    always_comb begin
        pe_xin = '0;
        pe_yin = '0;
        for (int i = 0; i < N; i++) begin
            pe_xin[i][0] = arr_x[i];
            pe_yin[0][i] = arr_y[i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                pe_xin[i][j] = pe_x[i][j-1];
                pe_yin[j][i] = pe_y[j-1][i];
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_x   <= '0;
            pe_y   <= '0;
            pe_acc <= '0;
        end else begin
            pe_x <= pe_xin;
            pe_y <= pe_yin;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pe_acc[i][j] <= (arr_init ? '0 : pe_acc[i][j])
                                    + ZW'(pe_xin[i][j]) * ZW'(pe_yin[i][j]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and checking
    // -------------------------------------------------------------------------
    typedef struct {
        logic [RW-1:0]    row;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   slot;
    int   nxt;
    bit   exp_first = 1'b0;
    bit   mon_pend_done = 1'b0;
    logic [AW-1:0] hist_a [16];
    logic [AW-1:0] hist_b [16];
    logic          hist_init [16];
    logic [AW-1:0] job_a [16];
    logic [AW-1:0] job_b [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) begin
            hist_a[s]    = '0;
            hist_b[s]    = '0;
            hist_init[s] = 1'b0;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 16; s++) begin
                hist_a[s]    = '0;
                hist_b[s]    = '0;
                hist_init[s] = 1'b0;
            end
            mon_pend_done = 1'b0;
        end else begin
            // Lane i shows what was accepted i edges before the current one.
            for (int i = 0; i < N; i++) begin
                slot = (cyc - i) & 15;
                check($sformatf("arr_x[%0d]", i), 64'(arr_x[i]), 64'(hist_a[slot][i*D_W +: D_W]));
                check($sformatf("arr_y[%0d]", i), 64'(arr_y[i]), 64'(hist_b[slot][i*D_W +: D_W]));
            end
            check("arr_init", 64'(arr_init), 64'(hist_init[cyc & 15]));
            nxt = (cyc + 1) & 15;
            hist_a[nxt]    = (op_valid && op_ready) ? op_a : '0;
            hist_b[nxt]    = (op_valid && op_ready) ? op_b : '0;
            hist_init[nxt] = op_valid && op_ready && exp_first;
            if (op_valid && op_ready) exp_first = 1'b0;

            check("done", 64'(done), 64'(mon_pend_done));
            mon_pend_done = 1'b0;

            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got row %0h with no job outstanding", res_row);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_row",  64'(res_row),  64'(mon_e.row));
                    check("res_idx",  64'(res_idx),  64'(mon_e.idx));
                    check("res_last", 64'(res_last), 64'(mon_e.last));
                    mon_pend_done = mon_e.last;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"},      64'(busy),      64'd0);
        check({tag, ":op_ready"},  64'(op_ready),  64'd0);
        check({tag, ":arr_init"},  64'(arr_init),  64'd0);
        check({tag, ":arr_x"},     64'(arr_x),     64'd0);
        check({tag, ":arr_y"},     64'(arr_y),     64'd0);
        check({tag, ":res_valid"}, 64'(res_valid), 64'd0);
        check({tag, ":res_row"},   64'(res_row),   64'd0);
        check({tag, ":res_idx"},   64'(res_idx),   64'd0);
        check({tag, ":res_last"},  64'(res_last),  64'd0);
        check({tag, ":done"},      64'(done),      64'd0);
    endtask

    task automatic issue_start(input logic [K_W-1:0] k);
        start     = 1'b1;
        k_len     = k;
        exp_first = (k != '0);
        tick();
        start = 1'b0;
        k_len = '0;
    endtask

    // Presents k beats from job_a/job_b. Before every beat except the first, it
    // inserts gap_fixed + rand(0..gap_rand) idle cycles. Garbage is driven on the
    // operand buses during gaps.
    task automatic feed_beats(input int k, input int gap_fixed, input int gap_rand);
        bit ok;
        int g;
        for (int kk = 0; kk < k; kk++) begin
            g = (kk == 0) ? 0 : gap_fixed + int'($urandom_range(gap_rand, 0));
            repeat (g) begin
                op_valid = 1'b0;
                op_a     = AW'($urandom);
                op_b     = AW'($urandom);
                tick();
            end
            op_valid = 1'b1;
            op_a     = job_a[kk];
            op_b     = job_b[kk];
            ok       = 1'b0;
            for (int w = 0; (w < 50) && !ok; w++) begin
                @(negedge clk);
                ok = op_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) check("op_ready_timeout", 64'd0, 64'd1);
        end
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic run_job(input int k, input int gap_fixed, input int gap_rand,
                           input int hold, input bit rand_ready, input bit start_busy);
        logic [ZW-1:0] sum;
        logic [RW-1:0] row;
        exp_t          e;
        int            t;
        // Reference: C = A * B over k beats, accumulated at the result width.
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                sum = '0;
                for (int kk = 0; kk < k; kk++) begin
                    sum += ZW'(job_a[kk][r*D_W +: D_W]) * ZW'(job_b[kk][j*D_W +: D_W]);
                end
                row[j*ZW +: ZW] = sum;
            end
            e.row  = row;
            e.idx  = IDX_W'(r);
            e.last = (r == N - 1);
            exp_q.push_back(e);
        end

        issue_start(K_W'(k));
        feed_beats(k, gap_fixed, gap_rand);

        if (start_busy) begin
            start = 1'b1;
            k_len = K_W'(3);
            tick();
            start = 1'b0;
            k_len = '0;
        end

        if (hold > 0) begin
            res_ready = 1'b0;
            t = 0;
            while (!res_valid && (t < 50)) begin
                tick();
                t++;
            end
            if (t >= 50) check("res_valid_timeout", 64'd0, 64'd1);
            repeat (hold) begin
                @(negedge clk);
                check("hold_res_valid", 64'(res_valid), 64'd1);
                check("hold_res_idx",   64'(res_idx),   64'd0);
                if (exp_q.size() > 0) check("hold_res_row", 64'(res_row), 64'(exp_q[0].row));
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
        end

        t = 0;
        while (((exp_q.size() != 0) || busy) && (t < 200)) begin
            if (rand_ready) res_ready = 1'($urandom_range(1, 0));
            tick();
            t++;
        end
        res_ready = 1'b1;
        if (t >= 200) check("job_timeout", 64'd0, 64'd1);
        tick();
        check("busy_after_job", 64'(busy), 64'd0);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    int rk;

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();
        check_all_zero("after_reset");

        // Worked example: rows [19,22] and [43,50].
        job_a[0] = {8'd3, 8'd1};
        job_b[0] = {8'd6, 8'd5};
        job_a[1] = {8'd4, 8'd2};
        job_b[1] = {8'd8, 8'd7};
        run_job(2, 0, 0, 0, 1'b0, 1'b0);
        // Same job with a 3-cycle gap between beats.
        run_job(2, 3, 0, 0, 1'b0, 1'b0);
        // Same job with res_ready held low for 5 cycles in OUT.
        run_job(2, 0, 0, 5, 1'b0, 1'b0);

        // Zero-length start is ignored.
        issue_start('0);
        repeat (3) begin
            @(negedge clk);
            check("klen0_busy", 64'(busy), 64'd0);
        end
        tick();

        // Start while busy is ignored.
        run_job(2, 0, 0, 0, 1'b0, 1'b1);

        // Reset in the middle of FEED.
        issue_start(K_W'(2));
        feed_beats(1, 0, 0);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_feed");
        tick();
        tick();
        rst       = 1'b1;
        exp_first = 1'b0;
        tick();
        check_all_zero("after_rst_feed");

        // Reset during DRAIN, then k_len=1: rows [8,10] and [12,15].
        issue_start(K_W'(2));
        feed_beats(2, 0, 0);
        tick();
        check("busy_in_drain", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_drain");
        tick();
        rst = 1'b1;
        tick();
        job_a[0] = {8'd3, 8'd2};
        job_b[0] = {8'd5, 8'd4};
        run_job(1, 0, 0, 0, 1'b0, 1'b0);

        // Randomised jobs with random stalls and result back-pressure.
        for (int n = 0; n < 10; n++) begin
            rk = int'($urandom_range(6, 1));
            for (int kk = 0; kk < rk; kk++) begin
                job_a[kk] = AW'($urandom);
                job_b[kk] = AW'($urandom);
            end
            run_job(rk, 0, 2, (n == 4) ? 3 : 0, 1'b1, n == 6);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
